// File: rtl/mux_2x1_24b.sv
// 2:1 operand selector for the FPU mantissa datapath with a combinational output
// and a registered, valid-tracked copy. Define PARITY_OUT_EN to add the registered X_par output.
module mux_2x1_24b #(
    parameter int              WIDTH     = 24,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             S,
    input  logic             in_valid,
    output logic [WIDTH-1:0] X,
    output logic [WIDTH-1:0] X_q,
`ifdef PARITY_OUT_EN
    output logic             X_par,
`endif
    output logic             out_valid
);

    logic [WIDTH-1:0] w_sel;
    logic [WIDTH-1:0] r_xq;
    logic             r_valid;

    // An if/else rather than a ternary, so an unknown select in simulation
    // resolves to A instead of merging the two operands.
    always_comb begin
        w_sel = A;
        if (S == 1'b1) begin
            w_sel = B;
        end
    end

    assign X = w_sel;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_xq    <= RESET_VAL;
            r_valid <= 1'b0;
        end else if (in_valid) begin
            r_xq    <= w_sel;
            r_valid <= 1'b1;
        end else begin
            r_valid <= 1'b0;
        end
    end

    assign X_q       = r_xq;
    assign out_valid = r_valid;

`ifdef PARITY_OUT_EN
    logic r_par;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_par <= 1'b0;
        end else if (in_valid) begin
            r_par <= ^w_sel;
        end
    end

    assign X_par = r_par;
`endif

endmodule

// File: tb/tb_mux_2x1_24b.sv
// Directed self-checking bench for mux_2x1_24b; registered results go through
// a scoreboard queue filled when stimulus is driven and drained after each edge.
module tb_mux_2x1_24b;

    logic        clk;
    logic        reset;
    logic [23:0] A;
    logic [23:0] B;
    logic        S;
    logic        in_valid;
    logic [23:0] X;
    logic [23:0] X_q;
    logic        out_valid;
`ifdef PARITY_OUT_EN
    logic        X_par;
`endif

    typedef struct {
        logic [23:0] xq;
        logic        valid;
        logic        par;
    } expT;

    expT         sbQueue[$];
    logic [23:0] mdlXq;
    logic        mdlPar;
    int          checks = 0;
    int          errors = 0;

    mux_2x1_24b dut (
        .clk      (clk),
        .reset    (reset),
        .A        (A),
        .B        (B),
        .S        (S),
        .in_valid (in_valid),
        .X        (X),
        .X_q      (X_q),
`ifdef PARITY_OUT_EN
        .X_par    (X_par),
`endif
        .out_valid(out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, then check the registered result after the rising edge.
    task automatic applyStimulus(input logic [23:0] a, input logic [23:0] b, input logic s,
                                 input logic v, input logic r);
        expT e;
        logic [23:0] sel;
        @(negedge clk);
        A = a; B = b; S = s; in_valid = v; reset = r;
        sel = (s == 1'b1) ? b : a;
        #1;
        checkOutput("X_comb", X, sel);
        if (r) begin
            mdlXq = 24'h0; mdlPar = 1'b0; e.valid = 1'b0;
        end else if (v) begin
            mdlXq = sel; mdlPar = ^sel; e.valid = 1'b1;
        end else begin
            e.valid = 1'b0;
        end
        e.xq = mdlXq;
        e.par = mdlPar;
        sbQueue.push_back(e);
        @(posedge clk);
        #1;
        if (sbQueue.size() == 0) begin
            checkOutput("scoreboard_empty", 24'h1, 24'h0);
        end else begin
            e = sbQueue.pop_front();
            checkOutput("X_q", X_q, e.xq);
            checkOutput("out_valid", {23'h0, out_valid}, {23'h0, e.valid});
`ifdef PARITY_OUT_EN
            checkOutput("X_par", {23'h0, X_par}, {23'h0, e.par});
`endif
            checkOutput("X_after_edge", X, sel);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL timeout observed running expected finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        reset = 1'b0; in_valid = 1'b0; A = 24'h1; B = 24'h2; S = 1'b0;
        mdlXq = 24'h0; mdlPar = 1'b0;

        // Combinational path before any clock edge or reset.
        #1 checkOutput("X_s0", X, 24'h1);
        S = 1'b1;
        #1 checkOutput("X_s1", X, 24'h2);
        S = 1'b0;
        #1 checkOutput("X_s0_back", X, 24'h1);

        applyStimulus(24'h1, 24'h2, 1'b0, 1'b0, 1'b1);
        applyStimulus(24'hFFFFFF, 24'h0, 1'b0, 1'b1, 1'b0);
        applyStimulus(24'hFFFFFF, 24'h0, 1'b0, 1'b0, 1'b0);

        // Reset wins over a coincident valid input.
        applyStimulus(24'h800000, 24'h000001, 1'b1, 1'b1, 1'b1);

        applyStimulus(24'h123456, 24'hABCDEF, 1'b0, 1'b1, 1'b0);
        applyStimulus(24'h123456, 24'hABCDEF, 1'b1, 1'b1, 1'b0);
        applyStimulus(24'h123456, 24'hABCDEF, 1'b0, 1'b1, 1'b0);
        applyStimulus(24'h123456, 24'hABCDEF, 1'b1, 1'b1, 1'b0);

        applyStimulus(24'h000007, 24'h000003, 1'b0, 1'b1, 1'b0);
        applyStimulus(24'h000007, 24'h000003, 1'b1, 1'b1, 1'b0);
        applyStimulus(24'h000007, 24'h000003, 1'b0, 1'b0, 1'b0);
        applyStimulus(24'h000007, 24'h000003, 1'b0, 1'b1, 1'b1);

        for (int i = 0; i < 16; i++) begin
            applyStimulus(24'($urandom), 24'($urandom), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_2x1_24b.md
Name: mux_2x1_24b

Overview:
- Data-path selector for the floating-point unit: picks one of two 24-bit operands (e.g. mantissa with hidden bit) under a 1-bit select.
- Provides a zero-latency combinational output, X, for existing datapath users.
- Also provides a registered copy, with valid tracking, for pipelined stages.
- Sits between the mantissa align/normalise logic and downstream adders/shifters.

Parameters:
- WIDTH, 24, data width of A, B, X and X_q.
- RESET_VAL, 0, value loaded into X_q on reset.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- A  input  WIDTH  operand selected when S=0.
- B  input  WIDTH  operand selected when S=1.
- S  input  1  select.
- in_valid  input  1  qualifies A/B/S for the registered path.
- X  output  WIDTH  combinational result: S ? B : A.
- X_q  output  WIDTH  registered result.
- out_valid  output  1  X_q holds data captured from a valid input.

Behaviour:
- X is purely combinational: X = A when S=0, X = B when S=1.
  - X is independent of clk, reset and in_valid.
  - X settles within the same delta/timestep as an input change.
- Registered path, on each rising clk edge:
  - If reset=1: X_q <= RESET_VAL and out_valid <= 0. Reset overrides in_valid.
  - Else if in_valid=1: X_q <= (S ? B : A) and out_valid <= 1.
  - Else: X_q holds its value and out_valid <= 0.
- Latency:
  - X: 0 cycles.
  - X_q/out_valid: 1 cycle after the sampling edge.
- Reset asserted mid-stream clears out_valid on that edge. Any in_valid on the same edge is dropped.
- There is no back-pressure; every valid input is captured.
- Full WIDTH bits pass unmodified: no sign extension, truncation or arithmetic.
- Any S value other than 1 (only 0 in synthesis) selects A.
- Outputs before the first reset:
  - X is defined by its inputs.
  - X_q and out_valid are undefined until reset is applied.

Optional Feature:
- Macro PARITY_OUT_EN.
- When defined:
  - Adds output X_par (1 bit), registered alongside X_q.
  - X_par is the even parity (XOR reduction) of the selected value, loaded when in_valid=1.
  - X_par is cleared to 0 on reset and held otherwise.
- When undefined: port X_par and its logic do not exist; all other behaviour is identical.

Test Plan:
- A=1, B=2, S=0 -> X=1 within the same timestep, with no clock needed.
- A=1, B=2, then S changes 0->1 -> X=2 immediately; back to S=0 -> X=1.
- reset=1 for 1 cycle, then A=24'hFFFFFF, B=0, S=0, in_valid=1 for one edge:
  - Before that edge: X_q=0, out_valid=0.
  - After it: X_q=24'hFFFFFF, out_valid=1.
  - Next edge with in_valid=0: out_valid=0 and X_q holds 24'hFFFFFF.
- A=24'h800000, B=24'h000001, S=1, in_valid=1 with reset=1 on the same edge -> X_q=0, out_valid=0; X still =24'h000001.
- Back-to-back in_valid with S toggling each cycle (A=24'h123456, B=24'hABCDEF) -> X_q alternates 123456/ABCDEF one cycle behind S, out_valid stays 1.
- With PARITY_OUT_EN: select 24'h000007 (three ones) -> X_par=1; select 24'h000003 -> X_par=0; reset -> X_par=0.
